// File: rtl/key_pulser.sv
// Debounces an asynchronous console key and emits one-clock pulses per accepted
// press, with optional auto-repeat while the key is held.
module key_pulser #(
  parameter int unsigned DEBOUNCE   = 20,
  parameter int unsigned REPEAT_DLY = 100,
  parameter int unsigned REPEAT_PER = 50,
  parameter int unsigned CW         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  input  logic rpt_en,
  output logic p,
  output logic l,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, PRESS_Q, HELD, REL_Q} state_t;

  localparam logic [CW-1:0] DB_C  = CW'(DEBOUNCE);
  localparam logic [CW-1:0] DLY_C = CW'(REPEAT_DLY);
  localparam logic [CW-1:0] PER_C = CW'(REPEAT_PER);
  localparam bit            DB_ONE = (DEBOUNCE == 1);

  state_t        state, state_n;
  logic          sync1, key_s;
  logic [CW-1:0] dcnt, dcnt_n, rcnt, rcnt_n;
  logic [CW-1:0] dinc, rtgt, rinc;
  logic          rep, rep_n;
  logic          p_n, l_n, busy_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      key_s <= 1'b0;
    end else begin
      sync1 <= key;
      key_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      dcnt  <= '0;
      rcnt  <= '0;
      rep   <= 1'b0;
      p     <= 1'b0;
      l     <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      dcnt  <= dcnt_n;
      rcnt  <= rcnt_n;
      rep   <= rep_n;
      p     <= p_n;
      l     <= l_n;
      busy  <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    rcnt_n  = rcnt;
    rep_n   = rep;
    p_n     = 1'b0;
    l_n     = l;
    dinc    = dcnt + 1'b1;
    rtgt    = rep ? PER_C : DLY_C;
    // rcnt saturates at its target so a repeat blocked by the previous pulse fires next cycle
    rinc    = (rcnt == rtgt) ? rcnt : rcnt + 1'b1;
    case (state)
      IDLE: begin
        if (key_s) begin
          if (DB_ONE) begin
            state_n = HELD;
            l_n     = 1'b1;
            p_n     = 1'b1;
            dcnt_n  = '0;
            rcnt_n  = '0;
            rep_n   = 1'b0;
          end else begin
            state_n = PRESS_Q;
            dcnt_n  = 1'b1;
          end
        end
      end
      PRESS_Q: begin
        if (!key_s) begin
          state_n = IDLE;
          dcnt_n  = '0;
        end else if (dinc == DB_C) begin
          state_n = HELD;
          l_n     = 1'b1;
          p_n     = 1'b1;
          dcnt_n  = '0;
          rcnt_n  = '0;
          rep_n   = 1'b0;
        end else begin
          dcnt_n = dinc;
        end
      end
      HELD: begin
        if (!key_s) begin
          rcnt_n = '0;
          rep_n  = 1'b0;
          if (DB_ONE) begin
            state_n = IDLE;
            l_n     = 1'b0;
            dcnt_n  = '0;
          end else begin
            state_n = REL_Q;
            dcnt_n  = 1'b1;
          end
        end else if (!rpt_en) begin
          rcnt_n = '0;
          rep_n  = 1'b0;
        end else if ((rinc == rtgt) && !p) begin
          p_n    = 1'b1;
          rcnt_n = '0;
          rep_n  = 1'b1;
        end else begin
          rcnt_n = rinc;
        end
      end
      REL_Q: begin
        if (key_s) begin
          state_n = HELD;
          dcnt_n  = '0;
          rcnt_n  = '0;
          rep_n   = 1'b0;
        end else if (dinc == DB_C) begin
          state_n = IDLE;
          l_n     = 1'b0;
          dcnt_n  = '0;
        end else begin
          dcnt_n = dinc;
        end
      end
      default: begin
        state_n = IDLE;
        dcnt_n  = '0;
        rcnt_n  = '0;
        rep_n   = 1'b0;
        l_n     = 1'b0;
      end
    endcase
    busy_n = (state_n == PRESS_Q) || (state_n == REL_Q);
  end

endmodule

// File: tb/tb_key_pulser.sv
// Directed bench for key_pulser: cycle-by-cycle vector table plus pulse-log
// sequences for repeat, glitch, reset-abort and DEBOUNCE=1 cases.
module tb_key_pulser;

  typedef struct packed {
    logic key;
    logic rpt;
    logic ep;
    logic el;
    logic eb;
  } vec_t;

  logic clk, reset;
  logic key0, rpt0, p0, l0, b0;
  logic key1, rpt1, p1, l1, b1;
  int   cyc;
  int   ntests, nfail;
  int   q0[$];
  int   q1[$];
  int   adj1;
  logic p1_prev;
  vec_t vt[$];

  key_pulser #(.DEBOUNCE(4), .REPEAT_DLY(10), .REPEAT_PER(3), .CW(16)) u0 (
    .clk(clk), .reset(reset), .key(key0), .rpt_en(rpt0), .p(p0), .l(l0), .busy(b0)
  );

  key_pulser #(.DEBOUNCE(1), .REPEAT_DLY(10), .REPEAT_PER(1), .CW(16)) u1 (
    .clk(clk), .reset(reset), .key(key1), .rpt_en(rpt1), .p(p1), .l(l1), .busy(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log: an entry N means p was high in the cycle following edge N.
  initial begin
    adj1    = 0;
    p1_prev = 1'b0;
  end
  always @(negedge clk) begin
    if (p0 === 1'b1) q0.push_back(cyc);
    if (p1 === 1'b1) q1.push_back(cyc);
    if ((p1 === 1'b1) && (p1_prev === 1'b1)) adj1 = adj1 + 1;
    p1_prev = p1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests = ntests + 1;
    if (act !== exp) begin
      nfail = nfail + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic addv(input logic k, input logic r, input logic ep, input logic el, input logic eb);
    vec_t v;
    v.key = k; v.rpt = r; v.ep = ep; v.el = el; v.eb = eb;
    vt.push_back(v);
  endtask

  task automatic add_release();
    addv(0,0, 0,1,0); addv(0,0, 0,1,0); addv(0,0, 0,1,1); addv(0,0, 0,1,1);
    addv(0,0, 0,1,1); addv(0,0, 0,0,0); addv(0,0, 0,0,0);
  endtask

  task automatic chk_log(input string nm, input int e0, input int exp[], input int q[$]);
    chk({nm, "_count"}, q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk({nm, "_pulse_at"}, (i < q.size()) ? q[i] - e0 : -1, exp[i]);
  endtask

  initial begin
    int e0, f0;
    int exp3[] = '{5, 15, 18, 21, 24, 27, 30};
    int exp4[] = '{5, 21, 24};
    int exp6[] = '{2, 12, 14, 16, 18, 20};

    ntests = 0;
    nfail  = 0;
    reset  = 1'b0;
    key0 = 1'b0; rpt0 = 1'b0;
    key1 = 1'b0; rpt1 = 1'b0;

    // Clean press (test 1): row = {key, rpt_en, expected p, l, busy after the edge}
    addv(1,0, 0,0,0); addv(1,0, 0,0,0); addv(1,0, 0,0,1); addv(1,0, 0,0,1);
    addv(1,0, 0,0,1); addv(1,0, 1,1,0); addv(1,0, 0,1,0); addv(1,0, 0,1,0);
    add_release();
    // Bounce 1,0,1,0,1 then steady high (test 2)
    addv(1,0, 0,0,0); addv(0,0, 0,0,0); addv(1,0, 0,0,1); addv(0,0, 0,0,0);
    addv(1,0, 0,0,1); addv(1,0, 0,0,0); addv(1,0, 0,0,1); addv(1,0, 0,0,1);
    addv(1,0, 0,0,1); addv(1,0, 1,1,0); addv(1,0, 0,1,0);
    add_release();

    repeat (3) @(negedge clk);
    chk("reset_p0", p0, 0); chk("reset_l0", l0, 0); chk("reset_busy0", b0, 0);
    chk("reset_p1", p1, 0); chk("reset_l1", l1, 0); chk("reset_busy1", b1, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      key0 = vt[i].key;
      rpt0 = vt[i].rpt;
      @(negedge clk);
      chk($sformatf("vec%0d_p", i), p0, vt[i].ep);
      chk($sformatf("vec%0d_l", i), l0, vt[i].el);
      chk($sformatf("vec%0d_busy", i), b0, vt[i].eb);
    end

    // Auto-repeat with key held for 30 sampled edges
    q0.delete();
    rpt0 = 1'b1; key0 = 1'b1; e0 = cyc + 1;
    goto(e0 + 29); key0 = 1'b0;
    goto(e0 + 34); chk("t3_l_before_fall", l0, 1);
    goto(e0 + 35); chk("t3_l_fall", l0, 0); chk("t3_busy_idle", b0, 0);
    goto(e0 + 45);
    chk_log("t3", e0, exp3, q0);
    rpt0 = 1'b0;

    // Two-cycle release glitch while held with repeat enabled
    q0.delete();
    rpt0 = 1'b1; key0 = 1'b1; e0 = cyc + 1;
    goto(e0 + 6); key0 = 1'b0;
    goto(e0 + 8); key0 = 1'b1;
    goto(e0 + 10); chk("t4_l_in_relq", l0, 1); chk("t4_busy_in_relq", b0, 1);
    goto(e0 + 11); chk("t4_l_back_held", l0, 1); chk("t4_busy_back_held", b0, 0);
    goto(e0 + 24); key0 = 1'b0;
    goto(e0 + 40);
    chk_log("t4", e0, exp4, q0);
    chk("t4_l_released", l0, 0);
    rpt0 = 1'b0;

    // Reset asserted during a repeat pulse with the key still held
    q0.delete();
    rpt0 = 1'b1; key0 = 1'b1; e0 = cyc + 1;
    goto(e0 + 15); chk("t5_p_before_reset", p0, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_p", p0, 0); chk("t5_async_l", l0, 0); chk("t5_async_busy", b0, 0);
    rpt0 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    q0.delete();
    f0 = cyc + 1;
    goto(f0 + 4); chk("t5_no_trailing_p", q0.size(), 0); chk("t5_requalify_busy", b0, 1);
    goto(f0 + 5); chk("t5_fresh_p", p0, 1); chk("t5_fresh_l", l0, 1);
    goto(f0 + 12);
    chk("t5_single_p", q0.size(), 1);
    chk("t5_p_at", (q0.size() > 0) ? q0[0] - f0 : -1, 5);
    key0 = 1'b0;
    goto(cyc + 10); chk("t5_l_released", l0, 0);

    // DEBOUNCE=1, REPEAT_PER=1 instance
    q1.delete();
    rpt1 = 1'b1; key1 = 1'b1; e0 = cyc + 1;
    goto(e0 + 1); chk("t6_l_before_accept", l1, 0);
    goto(e0 + 2); chk("t6_p_accept", p1, 1); chk("t6_busy", b1, 0);
    goto(e0 + 19); key1 = 1'b0;
    goto(e0 + 21); chk("t6_l_held", l1, 1);
    goto(e0 + 22); chk("t6_l_fall", l1, 0);
    goto(e0 + 30);
    chk_log("t6", e0, exp6, q1);
    chk("t6_no_adjacent_p", adj1, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
